conv_loop_scheduler: RTL

- Sequencing controller for the streaming convolution engine (input [BATCH,H,W,C_IN], weights [C_OUT,C_IN,KH,KW], output [BATCH,OH,OW,C_OUT]).
- On a start pulse it walks the full loop nest for one frame and emits one command per datapath beat on a valid/ready command stream.
- Each command carries loop indices plus accumulator first/last flags; the engine uses them to fetch buffers, clear and emit accumulators.
- Sits between the host control register (ap_start/ap_done style) and the engine datapath.

---
 rtl/conv_loop_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/conv_loop_scheduler.sv
// Loop-nest command scheduler for the streaming convolution engine: one command per datapath beat.
// Optional performance counters are compiled in with `define CONV_SCHED_PERF_EN.
//
// state  | meaning
// IDLE   | counters at zero, waiting for start
// RUN    | presenting commands, odometer advances on each handshake
// DONE   | one-cycle done pulse, then back to IDLE
module conv_loop_scheduler #(
   parameter int OH    = 30,
   parameter int OW    = 30,
   parameter int C_IN  = 32,
   parameter int C_OUT = 64,
   parameter int KH    = 3,
   parameter int KW    = 3,
   parameter int PE    = 16,
   parameter int SIMD  = 8,
   parameter int IDX_W = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             cmd_tvalid,
   input  logic             cmd_tready,
   output logic [IDX_W-1:0] cmd_oh,
   output logic [IDX_W-1:0] cmd_ow,
   output logic [IDX_W-1:0] cmd_cof,
   output logic [IDX_W-1:0] cmd_kh,
   output logic [IDX_W-1:0] cmd_kw,
   output logic [IDX_W-1:0] cmd_cif,
   output logic             cmd_first,
   output logic             cmd_acc_last,
   output logic             cmd_tlast
`ifdef CONV_SCHED_PERF_EN
   ,
   output logic [31:0]      perf_stall,
   output logic [31:0]      perf_cycles
`endif
);

   localparam int CIF_N = C_IN / SIMD;
   localparam int COF_N = C_OUT / PE;
   localparam logic [IDX_W-1:0] OH_MAX  = IDX_W'(OH - 1);
   localparam logic [IDX_W-1:0] OW_MAX  = IDX_W'(OW - 1);
   localparam logic [IDX_W-1:0] COF_MAX = IDX_W'(COF_N - 1);
   localparam logic [IDX_W-1:0] KH_MAX  = IDX_W'(KH - 1);
   localparam logic [IDX_W-1:0] KW_MAX  = IDX_W'(KW - 1);
   localparam logic [IDX_W-1:0] CIF_MAX = IDX_W'(CIF_N - 1);
   localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [IDX_W-1:0] oh_q, ow_q, cof_q, kh_q, kw_q, cif_q;
   logic [IDX_W-1:0] oh_nx, ow_nx, cof_nx, kh_nx, kw_nx, cif_nx;
   logic             hs;
   logic             cif_wrap, kw_wrap, kh_wrap, cof_wrap, ow_wrap;

   // Each wrap term includes every inner wrap, so it doubles as the carry into the next level.
   assign cif_wrap = (cif_q == CIF_MAX);
   assign kw_wrap  = cif_wrap && (kw_q == KW_MAX);
   assign kh_wrap  = kw_wrap && (kh_q == KH_MAX);
   assign cof_wrap = kh_wrap && (cof_q == COF_MAX);
   assign ow_wrap  = cof_wrap && (ow_q == OW_MAX);

   assign cmd_first    = (kh_q == '0) && (kw_q == '0) && (cif_q == '0);
   assign cmd_acc_last = kh_wrap;
   assign cmd_tlast    = ow_wrap && (oh_q == OH_MAX);

   assign cmd_oh  = oh_q;
   assign cmd_ow  = ow_q;
   assign cmd_cof = cof_q;
   assign cmd_kh  = kh_q;
   assign cmd_kw  = kw_q;
   assign cmd_cif = cif_q;

   assign hs = (state == S_RUN) && cmd_tready;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      busy       = 1'b0;
      done       = 1'b0;
      cmd_tvalid = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nx = S_RUN;
         end
         S_RUN: begin
            busy       = 1'b1;
            cmd_tvalid = 1'b1;
            if (cmd_tready && cmd_tlast) state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (abort) state_nx = S_IDLE;
   end

   // Odometer: the final tlast handshake wraps every level, leaving the counters at zero for IDLE.
   always_comb begin
      cif_nx = cif_wrap ? '0 : cif_q + ONE;
      kw_nx  = !cif_wrap ? kw_q  : (kw_wrap  ? '0 : kw_q + ONE);
      kh_nx  = !kw_wrap  ? kh_q  : (kh_wrap  ? '0 : kh_q + ONE);
      cof_nx = !kh_wrap  ? cof_q : (cof_wrap ? '0 : cof_q + ONE);
      ow_nx  = !cof_wrap ? ow_q  : (ow_wrap  ? '0 : ow_q + ONE);
      oh_nx  = !ow_wrap  ? oh_q  : (cmd_tlast ? '0 : oh_q + ONE);
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst || abort) begin
         oh_q  <= '0;
         ow_q  <= '0;
         cof_q <= '0;
         kh_q  <= '0;
         kw_q  <= '0;
         cif_q <= '0;
      end else if (hs) begin
         oh_q  <= oh_nx;
         ow_q  <= ow_nx;
         cof_q <= cof_nx;
         kh_q  <= kh_nx;
         kw_q  <= kw_nx;
         cif_q <= cif_nx;
      end
   end

`ifdef CONV_SCHED_PERF_EN
   logic [31:0] stall_q, cycles_q;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         stall_q  <= '0;
         cycles_q <= '0;
      end else if ((state == S_IDLE) && start && !abort) begin
         stall_q  <= '0;
         cycles_q <= '0;
      end else if (state == S_RUN) begin
         if (cycles_q != '1) cycles_q <= cycles_q + 32'd1;
         if (!cmd_tready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      end
   end

   assign perf_stall  = stall_q;
   assign perf_cycles = cycles_q;
`endif

endmodule
